// File: rtl/sysid_boot_checker.sv
// ---------------------------------------------------------------------------
// sysid_boot_checker
//   Avalon-MM read master placed next to the system-ID slave. After reset
//   (when AUTO_START=1) or on an accepted start pulse it reads the ID word
//   (address 0) and then the timestamp word (address 1), compares both with
//   the expected constants and reports pass / fail / timeout, so boot
//   firmware can confirm it matches the synthesized hardware.
//
// Ports
//   clock            in   system clock
//   reset_n          in   asynchronous active-low reset
//   start            in   request a new check (honoured only in IDLE/DONE)
//   avm_address      out  word address to the sysid slave
//   avm_read         out  read strobe, held stable while stalled
//   avm_readdata     in   read data, valid when read && !waitrequest
//   avm_waitrequest  in   slave stall
//   busy             out  check in progress (RD_ID, RD_TS, COMPARE)
//   done             out  result valid, held until the next accepted start
//   pass             out  both words matched
//   fail             out  mismatch or timeout
//   timeout          out  a read stalled for TIMEOUT_CYCLES cycles
//   id_value         out  captured ID word
//   ts_value         out  captured timestamp word
// ---------------------------------------------------------------------------
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1765793749,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_auto_pending;
    logic             r_read;
    logic             r_address;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [31:0]      r_id_value;
    logic [31:0]      r_ts_value;

    logic w_launch;
    logic w_expired;

    // A check starts from IDLE on start or on the first edge after reset
    // release (auto-start); from DONE only on start.
    assign w_launch  = ((r_state == S_IDLE) && (start || r_auto_pending)) ||
                       ((r_state == S_DONE) && start);

    // This stalled cycle is the TIMEOUT_CYCLES-th one of the current read.
    assign w_expired = avm_waitrequest && (r_wait_cnt == CNT_LAST);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, exactly like hardware.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_auto_pending <= AUTO_START;
            r_read         <= 1'b0;
            r_address      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_id_value     <= '0;
            r_ts_value     <= '0;
        end else begin
            // Auto-start is only ever honoured on the very first edge.
            r_auto_pending <= 1'b0;

            if (w_launch) begin
                r_state    <= S_RD_ID;
                r_wait_cnt <= '0;
                r_read     <= 1'b1;
                r_address  <= 1'b0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_timeout  <= 1'b0;
                r_id_value <= '0;
                r_ts_value <= '0;
            end else begin
                case (r_state)
                    S_RD_ID, S_RD_TS: begin
                        if (w_expired) begin
                            // Abandon the read; the unread word stays 0.
                            r_state   <= S_DONE;
                            r_read    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                            r_fail    <= 1'b1;
                            r_pass    <= 1'b0;
                        end else if (avm_waitrequest) begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end else if (r_state == S_RD_ID) begin
                            r_id_value <= avm_readdata;
                            r_address  <= 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= S_RD_TS;
                        end else begin
                            r_ts_value <= avm_readdata;
                            r_read     <= 1'b0;
                            r_state    <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        r_pass  <= (r_id_value == EXPECTED_ID) &&
                                   (r_ts_value == EXPECTED_TS);
                        r_fail  <= !((r_id_value == EXPECTED_ID) &&
                                     (r_ts_value == EXPECTED_TS));
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                    S_IDLE, S_DONE: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_read  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// ---------------------------------------------------------------------------
// tb_sysid_boot_checker
//   Scoreboard bench for sysid_boot_checker. A behavioural sysid slave with
//   programmable stall count and a "stuck" mode answers the reads. Expected
//   read addresses and final results are queued when a check is launched and
//   compared when the DUT issues reads / raises done.
// ---------------------------------------------------------------------------
module tb_sysid_boot_checker;

    localparam logic [31:0] TS_GOOD  = 32'h693F_DFD5;
    localparam logic [31:0] ID_GOOD  = 32'd0;
    localparam int          T_CYCLES = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] id_value, ts_value;

    sysid_boot_checker #(
        .EXPECTED_ID    (ID_GOOD),
        .EXPECTED_TS    (TS_GOOD),
        .TIMEOUT_CYCLES (T_CYCLES),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    // ---------------- slave model ----------------
    logic [31:0] slv_ts_word;
    int          stall_n;
    bit          stuck;
    int          stall_cnt;

    assign avm_waitrequest = avm_read &&
                             ((stuck && avm_address) || (stall_cnt < stall_n));
    assign avm_readdata    = (avm_read && !avm_waitrequest) ?
                             (avm_address ? slv_ts_word : ID_GOOD) : 32'hDEAD_BEEF;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         stall_cnt <= 0;
        else if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else                                  stall_cnt <= 0;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [31:0] id;
        logic [31:0] ts;
        int          lat;
    } exp_t;

    exp_t q_res[$];
    int   q_addr[$];
    int   t_start = 0;

    // Expected outcome of one check under the current slave configuration.
    task automatic push_expected();
        exp_t e;
        q_addr.push_back(0);
        if (stuck) begin
            e.pass = 1'b0; e.fail = 1'b1; e.timeout = 1'b1;
            e.id = ID_GOOD; e.ts = 32'd0;
            e.lat = stall_n + 1 + T_CYCLES;
        end else begin
            q_addr.push_back(1);
            e.pass    = (slv_ts_word == TS_GOOD);
            e.fail    = (slv_ts_word != TS_GOOD);
            e.timeout = 1'b0;
            e.id      = ID_GOOD;
            e.ts      = slv_ts_word;
            e.lat     = 2 * stall_n + 3;
        end
        q_res.push_back(e);
    endtask

    logic done_d     = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            done_d     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !stuck) begin
                check("hold_read", {31'd0, avm_read}, 32'd1);
                check("hold_addr", {31'd0, avm_address}, {31'd0, prev_addr});
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;

            if (avm_read && !avm_waitrequest) begin
                if (q_addr.size() == 0) check("sb_unexpected_read", 32'd1, 32'd0);
                else check("rd_addr", {31'd0, avm_address}, q_addr.pop_front());
            end

            if (!done) check("flags_idle", {29'd0, pass, fail, timeout}, 32'd0);

            if (done && !done_d) begin
                if (q_res.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_res.pop_front();
                    check("pass",    {31'd0, pass},    {31'd0, e.pass});
                    check("fail",    {31'd0, fail},    {31'd0, e.fail});
                    check("timeout", {31'd0, timeout}, {31'd0, e.timeout});
                    check("id_value", id_value, e.id);
                    check("ts_value", ts_value, e.ts);
                    check("latency", cyc - t_start, e.lat);
                    check("busy_done", {31'd0, busy}, 32'd0);
                    check("rd_done",   {31'd0, avm_read}, 32'd0);
                end
            end
            done_d = done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) @(negedge clock);
        if (!done) check("wait_done", 32'd0, 32'd1);
        @(negedge clock);
    endtask

    // Pulse start at a negedge; the following posedge is E0.
    task automatic run_check(input bit expect_clear);
        start = 1'b1;
        push_expected();
        @(posedge clock);
        @(negedge clock);
        start   = 1'b0;
        t_start = cyc;
        check("busy_start", {31'd0, busy}, 32'd1);
        check("rd_start",   {31'd0, avm_read}, 32'd1);
        if (expect_clear) begin
            check("clr_done", {28'd0, done, pass, fail, timeout}, 32'd0);
            check("clr_vals", id_value | ts_value, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {23'd0, avm_address, avm_read, busy, done, pass, fail, timeout,
                    |id_value, |ts_value}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        stall_n     = 0;
        stuck       = 1'b0;
        slv_ts_word = TS_GOOD;
        repeat (3) @(negedge clock);
        check_all_zero("reset_outputs");

        // 1: auto-start after reset, zero-wait slave, matching words
        push_expected();
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t_start = cyc;
        check("auto_busy", {31'd0, busy}, 32'd1);
        wait_done(50);
        repeat (2) @(negedge clock);

        // 2: timestamp mismatch
        slv_ts_word = TS_GOOD - 32'd1;
        run_check(1'b1);
        wait_done(50);

        // 3: three wait states on each read
        slv_ts_word = TS_GOOD;
        stall_n     = 3;
        run_check(1'b1);
        wait_done(50);

        // 4: address 1 stuck in waitrequest -> timeout
        stall_n = 0;
        stuck   = 1'b1;
        run_check(1'b1);
        wait_done(50);
        check("rd_after_timeout", {31'd0, avm_read}, 32'd0);
        stuck = 1'b0;

        // 5: start during RD_TS is ignored; start in DONE reruns
        stall_n = 3;
        run_check(1'b1);
        for (int i = 0; i < 20 && !(avm_read && avm_address); i++) @(negedge clock);
        check("reach_rd_ts", {31'd0, avm_read && avm_address}, 32'd1);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("busy_ignored", {31'd0, busy}, 32'd1);
        wait_done(50);
        repeat (10) @(negedge clock);
        check("no_requeue_busy", {31'd0, busy}, 32'd0);
        check("no_requeue_done", {31'd0, done}, 32'd1);
        stall_n = 0;
        run_check(1'b1);
        wait_done(50);

        // 6: reset during RD_ID, then auto-start rerun
        stall_n = 6;
        run_check(1'b1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset_mid_read");
        q_res.delete();
        q_addr.delete();
        repeat (2) @(negedge clock);
        stall_n = 0;
        push_expected();
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t_start = cyc;
        check("rerun_busy", {31'd0, busy}, 32'd1);
        wait_done(50);

        check("sb_results_left", q_res.size(), 32'd0);
        check("sb_reads_left",   q_addr.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
